// File: rtl/oka_11bit_seq_ctrl.sv
// oka_11bit_seq_ctrl
// Sequential GF(2) 11x11-bit polynomial multiplier controller. One external
// combinational 6-bit OKA core is time-shared across the three overlap-free
// Karatsuba sub-products (even, odd, even^odd). The sub-products are folded
// into the 21-bit product, which is returned over a valid/ready handshake.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready decoded from state)
//   a, b                11-bit operands, bit i = coefficient of x^i
//   out_valid/out_ready product handshake
//   y                   21-bit product a*b over GF(2)
//   mul_a, mul_b        6-bit operands driven to the shared core
//   mul_y               11-bit combinational product from the shared core
//
// Optional feature macro: OKA11_SEQ_BACK2BACK_EN
//   defined   : DONE retires the product and accepts new operands on the
//               same edge (in_ready = out_ready in DONE), 4-cycle throughput
//   undefined : operands are accepted only in IDLE, 5-cycle throughput
//
// Only N = 11 is supported; the even/odd split below is fixed to that width.
module oka_11bit_seq_ctrl #(
   parameter  int unsigned N  = 11,
   localparam int unsigned H  = (N + 1) / 2,
   localparam int unsigned PW = 2 * N - 1,
   localparam int unsigned CW = 2 * H - 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] y,
   output logic [H-1:0]  mul_a,
   output logic [H-1:0]  mul_b,
   input  logic [CW-1:0] mul_y
);

   // The odd half has one fewer coefficient, so P2 never exceeds degree 8.
   localparam int unsigned P2W = CW - 2;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL1 = 3'd1,
      MUL2 = 3'd2,
      MUL3 = 3'd3,
      DONE = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [CW-1:0]   p1_q, p1_d;
   logic [P2W-1:0]  p2_q, p2_d;
   logic [PW-1:0]   y_q, y_d;
   logic            out_valid_q, out_valid_d;

   logic [H-1:0]    ae, ao, am;
   logic [H-1:0]    be, bo, bm;
   logic [CW-2:0]   p2x;
   logic [PW-1:0]   y_comb;

   // Even/odd coefficient split of the latched operands.
   assign ae = {a_q[10], a_q[8], a_q[6], a_q[4], a_q[2], a_q[0]};
   assign ao = {1'b0,    a_q[9], a_q[7], a_q[5], a_q[3], a_q[1]};
   assign am = ae ^ ao;
   assign be = {b_q[10], b_q[8], b_q[6], b_q[4], b_q[2], b_q[0]};
   assign bo = {1'b0,    b_q[9], b_q[7], b_q[5], b_q[3], b_q[1]};
   assign bm = be ^ bo;

   // P2 widened so that P2[9] reads as zero in the overlap fold.
   assign p2x = {1'b0, p2_q};

   // Overlap fold: even bits P1[i]^P2[i-1], odd bits P1[i]^P2[i]^P3[i];
   // P3 is the live core output during MUL3.
   always_comb begin
      y_comb    = '0;
      y_comb[0] = p1_q[0];
      for (int i = 1; i < H * 2 - 1; i++) begin
         y_comb[2*i] = p1_q[i] ^ p2x[i-1];
      end
      for (int i = 0; i < H * 2 - 2; i++) begin
         y_comb[2*i+1] = p1_q[i] ^ p2x[i] ^ mul_y[i];
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         p1_q        <= '0;
         p2_q        <= '0;
         y_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Next-state, core operand steering and handshake decode.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      p1_d        = p1_q;
      p2_d        = p2_q;
      y_d         = y_q;
      out_valid_d = out_valid_q;
      in_ready    = 1'b0;
      mul_a       = '0;
      mul_b       = '0;

      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               state_d = MUL1;
            end
         end
         MUL1: begin
            mul_a   = ae;
            mul_b   = be;
            p1_d    = mul_y;
            state_d = MUL2;
         end
         MUL2: begin
            mul_a   = ao;
            mul_b   = bo;
            p2_d    = mul_y[P2W-1:0];
            state_d = MUL3;
         end
         MUL3: begin
            mul_a       = am;
            mul_b       = bm;
            y_d         = y_comb;
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
`ifdef OKA11_SEQ_BACK2BACK_EN
            in_ready = out_ready;
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (in_valid) begin
                  a_d     = a;
                  b_d     = b;
                  state_d = MUL1;
               end else begin
                  state_d = IDLE;
               end
            end
`else
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign y         = y_q;
   assign out_valid = out_valid_q;

endmodule
